clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent divider channels (1..8).
REQ-002 Parameter CNT_W, default 24: divisor/counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 12: divisor loaded into every channel at reset; must be >= 2.
REQ-004 Clk_12MHz  input  1  sole clock; all logic on rising edge.
REQ-005 Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Ch_en  input  NUM_CH  per-channel run request.
REQ-007 Div_val  input  NUM_CH*CNT_W  per-channel divisor, channel i in bits [i*CNT_W +: CNT_W].
REQ-008 Div_load  input  NUM_CH  one-cycle strobe; captures Div_val slice for channel i.
REQ-009 Clk_out  output  NUM_CH  divided clock, registered, glitch-free.
REQ-010 Tick  output  NUM_CH  one-cycle strobe coincident with each Clk_out rising edge.
REQ-011 Active  output  NUM_CH  channel running.
REQ-012 Div_err  output  NUM_CH  sticky flag: invalid divisor rejected.

Function
REQ-013 Each channel SHALL hold: active divisor D, pending divisor P with pending flag, counter cnt (CNT_W bits, 0..D-1).
REQ-014 Running channel period SHALL be exactly D input cycles; Clk_out high for floor(D/2) cycles, low for D-floor(D/2).
REQ-015 Idle channel with Ch_en=1 sampled at edge k: after edge k Active=1, Clk_out=1, Tick=1, cnt=0.
REQ-016 cnt SHALL increment each cycle while Active; at cnt=D-1 (period boundary) it wraps to 0 and Clk_out/Tick rise next cycle.
REQ-017 Tick SHALL be high exactly one cycle per period, never while idle.
REQ-018 Ch_en=0 at a period boundary: channel goes idle (Active=0, Clk_out=0, cnt=0); Ch_en toggling between boundaries SHALL have no effect.
REQ-019 Div_load with value >= 2: on running channel, stored in P, applied at the next boundary; on idle channel, applied to D immediately; Div_err cleared.
REQ-020 Div_load in the same cycle as a boundary SHALL apply at the following boundary, not the current one.
REQ-021 Second valid Div_load before application SHALL overwrite P (last write wins).
REQ-022 Div_load with value 0 or 1: rejected, D and P unchanged, Div_err set and held.
REQ-023 Channels SHALL be fully independent; no shared state beyond clock and reset.
REQ-024 Width rule: D and comparison of cnt against D-1 and floor(D/2) SHALL use CNT_W bits, no overflow for D = 2^CNT_W-1.

Reset
REQ-025 Rst_n low SHALL asynchronously force Clk_out=0, Tick=0, Active=0, Div_err=0, cnt=0, pending flag=0, D=DEFAULT_DIV, on all channels.
REQ-026 Reset release SHALL be synchronised internally (2-flop) before channel logic leaves reset; first possible Active edge is 2 cycles after release.
REQ-027 Reset asserted mid-period SHALL drop Clk_out low immediately; no partial pulse after release.

Structure
REQ-028 Package clk_div_pkg SHALL hold CNT_W default, DEFAULT_DIV, MIN_DIV=2 constants and the channel state type.
REQ-029 Per-channel logic SHALL be sub-module clk_div_channel, instantiated NUM_CH times by generate; top holds reset synchroniser and slicing only.

Verification
REQ-030 Reset, Ch_en[0]=1, D=12 -> Clk_out[0] period 12 cycles, high 6, Tick every 12th cycle; Active[0]=1.
REQ-031 D=3 and D=2 -> high 1/low 2 and high 1/low 1 respectively; Tick aligned to each rise.
REQ-032 Running D=12, Div_load value 4 at cnt=5 -> current period completes at 12 cycles, next periods 4 cycles; load at cnt=11 -> one more 12-cycle period first.
REQ-033 Div_load value 1 -> Div_err=1, period unchanged; then value 6 -> Div_err=0, period 6 from next boundary.
REQ-034 Ch_en deasserted at cnt=3 (D=12) -> Clk_out completes period, Active=0 after cnt=11, Clk_out stays 0; pulse Ch_en low for cnt 2..4 -> no effect.
REQ-035 Rst_n low at cnt=2 -> Clk_out=0 asynchronously; release -> all outputs 0 for 2 cycles, D back to 12; channel 1 D=5 runs unaffected by channel 0 loads.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and channel state encoding for the clock divider bank.
package clk_div_pkg;

  localparam int CNT_W_DEF   = 24;
  localparam int DEFAULT_DIV = 12;
  localparam int MIN_DIV     = 2;

  typedef logic [0:0] ch_state_t;
  localparam ch_state_t ST_IDLE = 1'b0;
  localparam ch_state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period D cycles, high for floor(D/2), divisor changes only at period boundaries.
// Latency: outputs registered, one cycle from the sampled enable/boundary; no backpressure.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ch_en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             active,
  output logic             div_err
);

  ch_state_t        state_q, state_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic             load_ok;
  logic             boundary;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;

  always_comb begin
    state_d  = state_q;
    d_d      = d_q;
    p_d      = p_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    clk_d    = clk_q;
    tick_d   = 1'b0;
    err_d    = err_q;

    load_ok  = div_load && (div_val >= CNT_W'(MIN_DIV));
    boundary = (state_q == ST_RUN) && (cnt_q == d_q - 1'b1);
    cnt_inc  = cnt_q + 1'b1;
    half     = d_q >> 1;

    case (state_q)
      ST_IDLE: begin
        // An idle channel has no period in flight, so a new divisor takes effect at once.
        if (load_ok) begin
          d_d = div_val;
        end else if (pend_q) begin
          d_d = p_q;
        end
        pend_d = 1'b0;
        if (ch_en) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clk_d   = 1'b1;
          tick_d  = 1'b1;
        end
      end
      default: begin
        if (boundary) begin
          if (pend_q) begin
            d_d    = p_q;
            pend_d = 1'b0;
          end
          cnt_d = '0;
          if (ch_en) begin
            clk_d  = 1'b1;
            tick_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            clk_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_inc;
          clk_d = (cnt_inc < half);
        end
        // A load landing on the boundary itself is held for the following boundary.
        if (load_ok) begin
          p_d    = div_val;
          pend_d = 1'b1;
        end
      end
    endcase

    if (div_load) begin
      err_d = !load_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      d_q     <= CNT_W'(DEFAULT_DIV);
      p_q     <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      p_q     <= p_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign active  = (state_q == ST_RUN);
  assign div_err = err_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent clock dividers sharing only clock and a synchronised reset.
// Latency: two-cycle reset-release delay, then per-channel registered outputs; no backpressure.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV
) (
  input  logic                    Clk_12MHz,
  input  logic                    Rst_n,
  input  logic [NUM_CH-1:0]       Ch_en,
  input  logic [NUM_CH*CNT_W-1:0] Div_val,
  input  logic [NUM_CH-1:0]       Div_load,
  output logic [NUM_CH-1:0]       Clk_out,
  output logic [NUM_CH-1:0]       Tick,
  output logic [NUM_CH-1:0]       Active,
  output logic [NUM_CH-1:0]       Div_err
);

  logic rst_meta_q, rst_meta_d;
  logic rst_sync_q, rst_sync_d;

  always_comb begin
    rst_meta_d = 1'b1;
    rst_sync_d = rst_meta_q;
  end

  // Assertion is asynchronous through these flops; only release is synchronised.
  always_ff @(posedge Clk_12MHz or negedge Rst_n) begin
    if (!Rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= rst_meta_d;
      rst_sync_q <= rst_sync_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk     (Clk_12MHz),
      .rst_n   (rst_sync_q),
      .ch_en   (Ch_en[g]),
      .div_val (Div_val[g*CNT_W +: CNT_W]),
      .div_load(Div_load[g]),
      .clk_out (Clk_out[g]),
      .tick    (Tick[g]),
      .active  (Active[g]),
      .div_err (Div_err[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: period shape, divisor reload timing, enable gating, reset.
module tb_clk_div_bank;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 24;

  logic                    clk;
  logic                    Rst_n;
  logic [NUM_CH-1:0]       Ch_en;
  logic [NUM_CH*CNT_W-1:0] Div_val;
  logic [NUM_CH-1:0]       Div_load;
  logic [NUM_CH-1:0]       Clk_out;
  logic [NUM_CH-1:0]       Tick;
  logic [NUM_CH-1:0]       Active;
  logic [NUM_CH-1:0]       Div_err;

  int checks;
  int errors;

  clk_div_bank #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(12)
  ) dut (
    .Clk_12MHz(clk),
    .Rst_n    (Rst_n),
    .Ch_en    (Ch_en),
    .Div_val  (Div_val),
    .Div_load (Div_load),
    .Clk_out  (Clk_out),
    .Tick     (Tick),
    .Active   (Active),
    .Div_err  (Div_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Checks one full period of channel ch starting at its cnt=0 sample; optionally
  // strobes a load at count load_at and holds Ch_en low over counts off_from..off_to.
  task automatic run_period(input int ch, input int d, input int load_at, input int load_val,
                            input int off_from, input int off_to);
    logic [2:0] got3;
    logic [2:0] exp3;
    for (int i = 0; i < d; i++) begin
      Div_load[ch] = 1'b0;
      if (i == load_at) begin
        Div_load[ch] = 1'b1;
        Div_val[ch*CNT_W +: CNT_W] = CNT_W'(load_val);
      end
      if (off_from >= 0) Ch_en[ch] = !((i >= off_from) && (i <= off_to));
      got3 = {Active[ch], Clk_out[ch], Tick[ch]};
      exp3 = {1'b1, (i < d / 2), (i == 0)};
      chk($sformatf("ch%0d d%0d c%0d act/clk/tick", ch, d, i), 32'(got3), 32'(exp3));
      @(negedge clk);
    end
    Div_load[ch] = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    Rst_n    = 1'b0;
    Ch_en    = '0;
    Div_val  = '0;
    Div_load = '0;

    repeat (3) @(negedge clk);
    chk("reset clk_out", 32'(Clk_out), 32'd0);
    chk("reset tick", 32'(Tick), 32'd0);
    chk("reset active", 32'(Active), 32'd0);
    chk("reset div_err", 32'(Div_err), 32'd0);

    // Release with channel 0 requested: two synchroniser cycles of silence, then start.
    Ch_en[0] = 1'b1;
    Rst_n    = 1'b1;
    @(negedge clk);
    chk("release +1 active", 32'(Active), 32'd0);
    @(negedge clk);
    chk("release +2 active", 32'(Active), 32'd0);
    chk("release +2 clk_out", 32'(Clk_out), 32'd0);
    @(negedge clk);

    run_period(0, 12, -1, 0, -1, -1);
    run_period(0, 12, -1, 0, -1, -1);

    // Load 4 mid-period: current 12-cycle period completes first.
    run_period(0, 12, 5, 4, -1, -1);
    run_period(0, 4, -1, 0, -1, -1);
    run_period(0, 4, 1, 12, -1, -1);
    // Load on the boundary cycle: one more 12-cycle period before switching.
    run_period(0, 12, 11, 4, -1, -1);
    run_period(0, 12, -1, 0, -1, -1);
    run_period(0, 4, 0, 3, -1, -1);

    run_period(0, 3, -1, 0, -1, -1);
    run_period(0, 3, 2, 2, -1, -1);
    run_period(0, 3, -1, 0, -1, -1);
    run_period(0, 2, -1, 0, -1, -1);
    run_period(0, 2, 0, 12, -1, -1);
    run_period(0, 12, -1, 0, -1, -1);

    // Invalid divisor rejected and sticky until a valid one arrives.
    run_period(0, 12, 4, 1, -1, -1);
    chk("err set by div 1", 32'(Div_err[0]), 32'd1);
    run_period(0, 12, -1, 0, -1, -1);
    chk("err held", 32'(Div_err[0]), 32'd1);
    run_period(0, 12, 3, 6, -1, -1);
    chk("err cleared by div 6", 32'(Div_err[0]), 32'd0);
    run_period(0, 6, 0, 12, -1, -1);
    run_period(0, 12, -1, 0, -1, -1);

    // Enable glitch between boundaries, then real disable at cnt 3.
    run_period(0, 12, -1, 0, 2, 4);
    run_period(0, 12, -1, 0, -1, -1);
    run_period(0, 12, -1, 0, 3, 99);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("idle %0d act/clk/tick", i), 32'({Active[0], Clk_out[0], Tick[0]}), 32'd0);
      @(negedge clk);
    end

    // Channel 1: idle load of 5 applies immediately; channel 0 loads must not disturb it.
    Div_val[CNT_W +: CNT_W] = CNT_W'(5);
    Div_load[1] = 1'b1;
    @(negedge clk);
    Div_load[1] = 1'b0;
    Ch_en[1]    = 1'b1;
    @(negedge clk);
    Div_val[0 +: CNT_W] = CNT_W'(9);
    Div_load[0] = 1'b1;
    run_period(1, 5, -1, 0, -1, -1);
    chk("ch0 idle during ch1 run", 32'(Active[0]), 32'd0);
    Div_val[0 +: CNT_W] = CNT_W'(1);
    run_period(1, 5, -1, 0, -1, -1);
    chk("err ch0 only", 32'(Div_err), 32'd1);

    // Restart channel 0 at D=12 with a simultaneous idle load.
    Div_val[0 +: CNT_W] = CNT_W'(12);
    Div_load[0] = 1'b1;
    Ch_en[0]    = 1'b1;
    @(negedge clk);
    Div_load[0] = 1'b0;
    chk("err ch0 cleared", 32'(Div_err[0]), 32'd0);
    run_period(0, 12, -1, 0, -1, -1);
    @(negedge clk);
    @(negedge clk);

    // Reset mid-period at cnt 2: clock drops before the next edge.
    #2 Rst_n = 1'b0;
    #1;
    chk("async reset clk_out", 32'(Clk_out), 32'd0);
    chk("async reset active", 32'(Active), 32'd0);
    chk("async reset tick", 32'(Tick), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("in reset div_err", 32'(Div_err), 32'd0);
    Rst_n = 1'b1;
    @(negedge clk);
    chk("rerelease +1 outputs", 32'({Active, Clk_out, Tick}), 32'd0);
    @(negedge clk);
    chk("rerelease +2 outputs", 32'({Active, Clk_out, Tick}), 32'd0);
    @(negedge clk);
    chk("rerelease +3 active", 32'(Active), 32'd3);
    run_period(0, 12, -1, 0, -1, -1);
    run_period(1, 12, -1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
